// File: rtl/dinorun_pkg.sv
// Shared types and constants for the dino runner.
// Holds screen dimensions, score width and the screen state encoding.
// No logic; imported by the screen sequencer and its helpers.
package dinorun_pkg;

    localparam int ScreenWidth  = 640;
    localparam int ScreenHeight = 480;
    localparam int ScoreWidth   = 16;

    typedef enum logic [1:0] {
        TITLE     = 2'd0,
        START     = 2'd1,
        PLAYING   = 2'd2,
        GAME_OVER = 2'd3
    } screen_state_e;

endpackage

// File: rtl/screen_ctrl_frame_divider.sv
// Counts qualified frame ticks and flags every Div-th one.
// wrap_o is combinational in the cycle of the Div-th tick; counter updates on that edge.
// No backpressure: a tick is counted whenever en_i and tick_i are both high.
module frame_divider #(
    parameter int Div = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic tick_i,
    output logic wrap_o
);

    localparam int CntW = $clog2(Div + 1);
    localparam logic [CntW-1:0] Last = CntW'(Div - 1);

    logic [CntW-1:0] cnt;

    assign wrap_o = en_i & tick_i & (cnt == Last);

    // Count qualified ticks, returning to zero on the wrapping tick or on clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i && tick_i) begin
            cnt <= wrap_o ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/screen_ctrl.sv
// Screen sequencer: title -> start -> play -> game over, score keeping and pixel compositing.
// pixel_o is combinational (zero latency); state-decoded outputs change on the clock edge.
// No backpressure: every input is sampled each cycle.
module screen_ctrl
    import dinorun_pkg::*;
#(
    parameter int BlinkFrames        = 30,
    parameter int GameOverHoldFrames = 60,
    parameter int ScoreDivFrames     = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  next_frame_i,
    input  logic                  button_i,
    input  logic                  collision_i,
    input  logic                  title_pixel_i,
    input  logic                  game_pixel_i,
    input  logic                  gameover_pixel_i,
    output logic                  pixel_o,
    output logic [1:0]            state_o,
    output logic                  game_run_o,
    output logic                  game_rst_o,
    output logic [ScoreWidth-1:0] score_o
);

    localparam int HoldW = $clog2(GameOverHoldFrames + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(GameOverHoldFrames);
    localparam logic [ScoreWidth-1:0] ScoreMax = '1;

    screen_state_e         state;
    screen_state_e         state_next;
    logic                  button_q;
    logic                  btn_rise;
    logic                  blink_on;
    logic                  blink_wrap;
    logic                  score_wrap;
    logic [HoldW-1:0]      hold_cnt;
    logic [ScoreWidth-1:0] score;

    assign btn_rise = button_i & ~button_q;
    assign state_o  = state;
    assign score_o  = score;

    // Title blink: toggles every BlinkFrames frames while on the title screen.
    frame_divider #(.Div(BlinkFrames)) u_blink_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (1'b0),
        .en_i   (state == TITLE),
        .tick_i (next_frame_i),
        .wrap_o (blink_wrap)
    );

    // Score pacing: a collision frame is not counted, so collision wins over the score tick.
    frame_divider #(.Div(ScoreDivFrames)) u_score_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state == START),
        .en_i   ((state == PLAYING) && !collision_i),
        .tick_i (next_frame_i),
        .wrap_o (score_wrap)
    );

    // State register plus button edge history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= TITLE;
            button_q <= 1'b0;
        end else begin
            state    <= state_next;
            button_q <= button_i;
        end
    end

    // Next-state decode; early game-over presses are simply dropped.
    always_comb begin
        state_next = state;
        case (state)
            TITLE:     if (btn_rise) state_next = START;
            START:     state_next = PLAYING;
            PLAYING:   if (collision_i) state_next = GAME_OVER;
            GAME_OVER: if (btn_rise && (hold_cnt == HoldMax)) state_next = START;
            default:   state_next = TITLE;
        endcase
    end

    // Run/reset strobes registered from the next state so they track state without glitches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            game_run_o <= 1'b0;
            game_rst_o <= 1'b0;
        end else begin
            game_run_o <= (state_next == PLAYING);
            game_rst_o <= (state_next == START);
        end
    end

    // Blink phase, starts visible.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_on <= 1'b1;
        end else if (blink_wrap) begin
            blink_on <= ~blink_on;
        end
    end

    // Game-over hold timer saturates so the restart window stays open.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt <= '0;
        end else if (state == START) begin
            hold_cnt <= '0;
        end else if ((state == GAME_OVER) && next_frame_i && (hold_cnt != HoldMax)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Score cleared on start, saturating increment on each divider wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            score <= '0;
        end else if (state == START) begin
            score <= '0;
        end else if (score_wrap && (score != ScoreMax)) begin
            score <= score + 1'b1;
        end
    end

    // Pixel compositing by screen.
    always_comb begin
        pixel_o = 1'b0;
        case (state)
            TITLE:          pixel_o = title_pixel_i & blink_on;
            START, PLAYING: pixel_o = game_pixel_i;
            GAME_OVER:      pixel_o = game_pixel_i | gameover_pixel_i;
            default:        pixel_o = 1'b0;
        endcase
    end

endmodule
